// File: rtl/intra_filter_accumulator.sv
// Per-lane tap accumulator for intra angular prediction. It sums TAPS signed MCM
// products, then rounds, shifts and clips the total into an unsigned predicted sample.
module intra_filter_accumulator #(
  parameter int IN_W  = 16,
  parameter int TAPS  = 4,
  parameter int SHIFT = 6,
  parameter int OUT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic signed [IN_W-1:0] in_product,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_sample,
  output logic                   busy
);

  localparam int CNT_W = $clog2(TAPS);
  localparam int ACC_W = IN_W + $clog2(TAPS) + 1;
  localparam int RND_W = ACC_W + 1;
  localparam logic [CNT_W-1:0]        LAST_TAP = CNT_W'(TAPS - 1);
  localparam logic signed [RND_W-1:0] ROUND    = RND_W'(longint'(1) << (SHIFT - 1));
  localparam logic signed [RND_W-1:0] MAX_R    = RND_W'((longint'(1) << OUT_W) - 1);

  logic [CNT_W-1:0]        tap_cnt_q, tap_cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_sample_q, out_sample_d;

  logic                    accept;
  logic                    final_tap;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [RND_W-1:0] rounded;
  logic signed [RND_W-1:0] shifted;
  logic [OUT_W-1:0]        clipped;

  assign final_tap = (tap_cnt_q == LAST_TAP);
  assign in_ready  = !final_tap || !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;

  always_comb begin
    prod_ext = {{(ACC_W - IN_W){in_product[IN_W-1]}}, in_product};
    sum      = ((tap_cnt_q == '0) ? '0 : acc_q) + prod_ext;
    // One extra bit so the rounding offset cannot wrap a full-scale sum.
    rounded  = {sum[ACC_W-1], sum} + ROUND;
    shifted  = rounded >>> SHIFT;
    if (shifted < 0)
      clipped = '0;
    else if (shifted > MAX_R)
      clipped = '1;
    else
      clipped = shifted[OUT_W-1:0];
  end

  always_comb begin
    tap_cnt_d    = tap_cnt_q;
    acc_d        = acc_q;
    out_valid_d  = out_valid_q;
    out_sample_d = out_sample_q;

    if (out_valid_q && out_ready)
      out_valid_d = 1'b0;

    if (accept) begin
      if (final_tap) begin
        tap_cnt_d    = '0;
        acc_d        = '0;
        out_valid_d  = 1'b1;
        out_sample_d = clipped;
      end else begin
        tap_cnt_d = tap_cnt_q + 1'b1;
        acc_d     = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tap_cnt_q    <= '0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
    end else begin
      tap_cnt_q    <= tap_cnt_d;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign busy       = (tap_cnt_q != '0);

endmodule

// File: tb/tb_intra_filter_accumulator.sv
// Directed self-checking bench for intra_filter_accumulator with the default parameters
// (IN_W=16, TAPS=4, SHIFT=6, OUT_W=8).
module tb_intra_filter_accumulator;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_product;
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_sample;
  logic               busy;

  int total = 0;
  int bad   = 0;

  intra_filter_accumulator #(
    .IN_W (16),
    .TAPS (4),
    .SHIFT(6),
    .OUT_W(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_product(in_product),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sample(out_sample),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one tap, waits (bounded) for in_ready, then clocks it in.
  task automatic send_tap(input logic signed [15:0] v);
    int unsigned n = 0;
    in_valid   = 1'b1;
    in_product = v;
    #1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL tap_wait: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run4(input logic signed [15:0] a, input logic signed [15:0] b,
                      input logic signed [15:0] c, input logic signed [15:0] d);
    send_tap(a); send_tap(b); send_tap(c); send_tap(d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_product = '0; out_ready = 1'b1;
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b exp 0", out_valid); end
    total++; if (out_sample !== 8'd0) begin bad++; $display("FAIL rst_out_sample: got %0d exp 0", out_sample); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b exp 0", busy); end
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %0b exp 1", in_ready); end
  endtask

  task automatic test_basic();
    logic signed [15:0] taps [3];
    out_ready = 1'b1;
    taps[0] = -16; taps[1] = 1000; taps[2] = 3000;
    for (int i = 0; i < 3; i++) begin
      send_tap(taps[i]);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy%0d: got %0b exp 1", i, busy); end
    end
    send_tap(-16'sd100);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %0b exp 1", out_valid); end
    total++; if (out_sample !== 8'd61) begin bad++; $display("FAIL basic_sample: got %0d exp 61", out_sample); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %0b exp 0", busy); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain: got %0b exp 0", out_valid); end
  endtask

  task automatic test_clip_round();
    logic signed [15:0] v [7][4];
    logic [7:0]         exp_s [7];
    v[0] = '{16'sd8000, 16'sd8000, 16'sd8000, 16'sd8000};    exp_s[0] = 8'd255;
    v[1] = '{16'sd16320, 16'sd16320, 16'sd16320, 16'sd16320}; exp_s[1] = 8'd255;
    v[2] = '{-16'sd300, -16'sd300, 16'sd0, 16'sd0};          exp_s[2] = 8'd0;
    v[3] = '{16'sd10, 16'sd10, 16'sd10, 16'sd2};             exp_s[3] = 8'd1;
    v[4] = '{16'sd10, 16'sd10, 16'sd10, 16'sd1};             exp_s[4] = 8'd0;
    v[5] = '{-16'sd11, -16'sd11, -16'sd11, 16'sd0};          exp_s[5] = 8'd0;
    v[6] = '{16'sd1000, 16'sd2000, 16'sd3000, 16'sd4000};    exp_s[6] = 8'd156;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      run4(v[i][0], v[i][1], v[i][2], v[i][3]);
      total++;
      if (out_valid !== 1'b1 || out_sample !== exp_s[i]) begin
        bad++;
        $display("FAIL clip_round%0d: got valid=%0b sample=%0d exp valid=1 sample=%0d",
                 i, out_valid, out_sample, exp_s[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    run4(64, 64, 64, 64);
    out_ready = 1'b0;
    total++; if (out_sample !== 8'd4) begin bad++; $display("FAIL bp_first: got %0d exp 4", out_sample); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_product = 16'sd640; #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready%0d: got %0b exp 1", i, in_ready); end
      tick();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_sample !== 8'd4) begin
        bad++; $display("FAIL bp_hold%0d: got valid=%0b sample=%0d exp valid=1 sample=4", i, out_valid, out_sample);
      end
    end
    in_valid = 1'b1; in_product = 16'sd640; #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall: got %0b exp 0", in_ready); end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_sample !== 8'd4 || busy !== 1'b1) begin
      bad++; $display("FAIL bp_stall_hold: got valid=%0b sample=%0d busy=%0b exp 1/4/1", out_valid, out_sample, busy);
    end
    out_ready = 1'b1; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got %0b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_sample !== 8'd40 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_second: got valid=%0b sample=%0d busy=%0b exp 1/40/0", out_valid, out_sample, busy);
    end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_dup: got %0b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] v [8];
    v = '{16'sd100, 16'sd200, 16'sd300, 16'sd400, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_product = v[i]; #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d: got %0b exp 1", i, in_ready); end
      tick();
      if (i == 3) begin
        total++; if (out_valid !== 1'b1 || out_sample !== 8'd16) begin
          bad++; $display("FAIL b2b_s0: got valid=%0b sample=%0d exp 1/16", out_valid, out_sample); end
      end
      if (i == 4) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap: got %0b exp 0", out_valid); end
      end
      if (i == 7) begin
        total++; if (out_valid !== 1'b1 || out_sample !== 8'd63) begin
          bad++; $display("FAIL b2b_s1: got valid=%0b sample=%0d exp 1/63", out_valid, out_sample); end
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    run4(640, 640, 640, 640);
    send_tap(16'sd5000);
    send_tap(16'sd5000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sample !== 8'd0) begin
      bad++; $display("FAIL midrst_clear: got valid=%0b busy=%0b sample=%0d exp 0/0/0", out_valid, busy, out_sample);
    end
    out_ready = 1'b1;
    run4(64, 64, 64, 64);
    total++; if (out_valid !== 1'b1 || out_sample !== 8'd4) begin
      bad++; $display("FAIL midrst_sample: got valid=%0b sample=%0d exp 1/4", out_valid, out_sample); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip_round();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
